// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and payload types for the writeback (common data bus) path.
// Requester 0 is the RS/ALU result path, requester 1 the SLB load path.
package cdb_arbiter_pkg;

   localparam int ROB_IDX_W = 4;
   localparam int DATA_W    = 32;
   localparam int MAX_ROB   = 1 << ROB_IDX_W;
   localparam int N_REQ_MAX = 4;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [DATA_W-1:0]    value;
      logic [DATA_W-1:0]    jumppc;
   } cdb_payload_t;

   typedef struct packed {
      logic         valid;
      cdb_payload_t pl;
   } cdb_slot_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping modulo N_REQ. Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int SRC_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [SRC_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [SRC_W-1:0] o_grant_idx,
   output logic             o_any
);

   int w_pos;

   // Walk offsets from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      w_pos       = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_pos = (int'(i_ptr) + k) % N_REQ;
         if (i_req[w_pos]) begin
            o_grant        = '0;
            o_grant[w_pos] = 1'b1;
            o_grant_idx    = SRC_W'(w_pos);
            o_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: one holding slot per producer, round-robin grant,
// and a registered CDB beat into the ROB write port each cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int SRC_W = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_rdy,
   input  logic                       i_clear,
   input  logic [N_REQ-1:0]           i_req_valid,
   output logic [N_REQ-1:0]           o_req_ready,
   input  logic [N_REQ*ROB_IDX_W-1:0] i_req_rob_idx,
   input  logic [N_REQ*DATA_W-1:0]    i_req_value,
   input  logic [N_REQ*DATA_W-1:0]    i_req_jumppc,
   output logic                       o_cdb_valid,
   output logic [SRC_W-1:0]           o_cdb_src,
   output logic [ROB_IDX_W-1:0]       o_cdb_rob_idx,
   output logic [DATA_W-1:0]          o_cdb_value,
   output logic [DATA_W-1:0]          o_cdb_jumppc
);

   logic [N_REQ-1:0] w_slot_v;
   cdb_payload_t     w_slot_pl [N_REQ];
   cdb_payload_t     w_req_pl  [N_REQ];
   logic [N_REQ-1:0] w_grant;
   logic [SRC_W-1:0] w_grant_idx;
   logic             w_any;
   logic [SRC_W-1:0] w_rr_next;

   logic             r_cdb_valid;
   logic [SRC_W-1:0] r_cdb_src;
   cdb_payload_t     r_cdb_pl;
   logic [SRC_W-1:0] r_rr_ptr;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .SRC_W (SRC_W)
   ) u_rr (
      .i_req       (w_slot_v),
      .i_ptr       (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slot
         cdb_slot_t r_slot;

         assign w_req_pl[gi] = {i_req_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W],
                                i_req_value[gi*DATA_W +: DATA_W],
                                i_req_jumppc[gi*DATA_W +: DATA_W]};

         // A granted slot drains this edge, so it can take a new result at once.
         assign o_req_ready[gi] = i_rdy & ~i_clear & (~r_slot.valid | w_grant[gi]);
         assign w_slot_v[gi]    = r_slot.valid;
         assign w_slot_pl[gi]   = r_slot.pl;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_slot <= '0;
            end else if (i_rdy) begin
               if (i_clear) begin
                  r_slot.valid <= 1'b0;
               end else if (i_req_valid[gi] && o_req_ready[gi]) begin
                  r_slot.valid <= 1'b1;
                  r_slot.pl    <= w_req_pl[gi];
               end else if (w_grant[gi]) begin
                  r_slot.valid <= 1'b0;
               end
            end
         end
      end
   endgenerate

   assign w_rr_next = (w_grant_idx == SRC_W'(N_REQ - 1)) ? '0 : w_grant_idx + SRC_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cdb_valid <= 1'b0;
         r_cdb_src   <= '0;
         r_cdb_pl    <= '0;
         r_rr_ptr    <= '0;
      end else if (i_rdy) begin
         if (i_clear) begin
            r_cdb_valid <= 1'b0;
            r_rr_ptr    <= '0;
         end else if (w_any) begin
            r_cdb_valid <= 1'b1;
            r_cdb_src   <= w_grant_idx;
            r_cdb_pl    <= w_slot_pl[w_grant_idx];
            r_rr_ptr    <= w_rr_next;
         end else begin
            r_cdb_valid <= 1'b0;
         end
      end
   end

   assign o_cdb_valid   = r_cdb_valid;
   assign o_cdb_src     = r_cdb_src;
   assign o_cdb_rob_idx = r_cdb_pl.rob_idx;
   assign o_cdb_value   = r_cdb_pl.value;
   assign o_cdb_jumppc  = r_cdb_pl.jumppc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench for cdb_arbiter: driver predicts each edge's beat from a
// slot/pointer reference model; a posedge monitor pops and compares.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 2;
   localparam int SW = 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rdy = 1'b1;
   logic            clear = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*4-1:0]  req_rob_idx = '0;
   logic [N*32-1:0] req_value = '0;
   logic [N*32-1:0] req_jumppc = '0;
   logic            cdb_valid;
   logic [SW-1:0]   cdb_src;
   logic [3:0]      cdb_rob_idx;
   logic [31:0]     cdb_value;
   logic [31:0]     cdb_jumppc;

   always #5 clk = ~clk;

   cdb_arbiter #(.N_REQ(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_rdy         (rdy),
      .i_clear       (clear),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_rob_idx (req_rob_idx),
      .i_req_value   (req_value),
      .i_req_jumppc  (req_jumppc),
      .o_cdb_valid   (cdb_valid),
      .o_cdb_src     (cdb_src),
      .o_cdb_rob_idx (cdb_rob_idx),
      .o_cdb_value   (cdb_value),
      .o_cdb_jumppc  (cdb_jumppc)
   );

   // mode: 0 normal beat/no-beat, 1 frozen (repeat previous), 2 reset (all zero)
   typedef struct {
      int          mode;
      bit          v;
      int          src;
      logic [3:0]  idx;
      logic [31:0] val;
      logic [31:0] jpc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   beats[N];

   bit          pend_v[N];
   logic [3:0]  pend_idx[N];
   logic [31:0] pend_val[N];
   logic [31:0] pend_jpc[N];

   bit          m_v[N];
   logic [3:0]  m_idx[N];
   logic [31:0] m_val[N];
   logic [31:0] m_jpc[N];
   int          m_rr = 0;

   task automatic offer(input int i, input logic [3:0] idx, input logic [31:0] val,
                        input logic [31:0] jpc);
      if (!pend_v[i]) begin
         pend_v[i]   = 1'b1;
         pend_idx[i] = idx;
         pend_val[i] = val;
         pend_jpc[i] = jpc;
      end
   endtask

   task automatic step(input bit s_rst, input bit s_rdy, input bit s_clr);
      exp_t e;
      int   g;
      bit   mr[N];
      @(negedge clk);
      rst   = s_rst;
      rdy   = s_rdy;
      clear = s_clr;
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = pend_v[i];
         req_rob_idx[i*4 +: 4] = pend_idx[i];
         req_value[i*32 +: 32] = pend_val[i];
         req_jumppc[i*32 +: 32] = pend_jpc[i];
      end
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && m_v[(m_rr + k) % N]) g = (m_rr + k) % N;
      for (int i = 0; i < N; i++)
         mr[i] = s_rdy && !s_clr && (!m_v[i] || g == i);
      #1;
      if (!s_rst) begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (req_ready[i] !== mr[i]) begin
               errors++;
               $display("FAIL req_ready[%0d] got %b want %b at %0t", i, req_ready[i], mr[i], $time);
            end
         end
      end
      e.mode = 0; e.v = 0; e.src = 0; e.idx = '0; e.val = '0; e.jpc = '0;
      if (s_rst) begin
         e.mode = 2;
         m_rr = 0;
         for (int i = 0; i < N; i++) begin
            m_v[i] = 0; pend_v[i] = 0;
         end
      end else if (!s_rdy) begin
         e.mode = 1;
      end else if (s_clr) begin
         m_rr = 0;
         for (int i = 0; i < N; i++) begin
            m_v[i] = 0; pend_v[i] = 0;
         end
      end else begin
         if (g >= 0) begin
            e.v = 1; e.src = g;
            e.idx = m_idx[g]; e.val = m_val[g]; e.jpc = m_jpc[g];
            m_v[g] = 0;
            m_rr = (g + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (pend_v[i] && mr[i]) begin
               m_v[i] = 1;
               m_idx[i] = pend_idx[i]; m_val[i] = pend_val[i]; m_jpc[i] = pend_jpc[i];
               pend_v[i] = 0;
            end
         end
      end
      sb.push_back(e);
   endtask

   exp_t        mon_e;
   logic [68:0] prev_out = '0;
   logic [68:0] cur_out;

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e   = sb.pop_front();
         cur_out = {cdb_valid, cdb_rob_idx, cdb_value, cdb_jumppc};
         checks++;
         if (mon_e.mode == 2) begin
            if (cur_out !== '0 || cdb_src !== '0) begin
               errors++;
               $display("FAIL reset_outputs got v=%b src=%0d idx=%0d val=%h jpc=%h want all 0",
                        cdb_valid, cdb_src, cdb_rob_idx, cdb_value, cdb_jumppc);
            end
         end else if (mon_e.mode == 1) begin
            if (cur_out !== prev_out) begin
               errors++;
               $display("FAIL freeze got %h want %h at %0t", cur_out, prev_out, $time);
            end
         end else if (cdb_valid !== mon_e.v) begin
            errors++;
            $display("FAIL cdb_valid got %b want %b at %0t", cdb_valid, mon_e.v, $time);
         end else if (mon_e.v) begin
            beats[mon_e.src]++;
            if (cdb_src !== SW'(mon_e.src) || cdb_rob_idx !== mon_e.idx ||
                cdb_value !== mon_e.val || cdb_jumppc !== mon_e.jpc) begin
               errors++;
               $display("FAIL beat got src=%0d idx=%0d val=%h jpc=%h want src=%0d idx=%0d val=%h jpc=%h",
                        cdb_src, cdb_rob_idx, cdb_value, cdb_jumppc,
                        mon_e.src, mon_e.idx, mon_e.val, mon_e.jpc);
            end
         end
         prev_out = cur_out;
      end
   end

   task automatic check_count(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      int b0, b1, n0, n1;
      step(1, 1, 0);
      step(1, 1, 0);
      step(0, 1, 0);
      $display("reset phase done");

      // single result: RS idx 3, value 0x2A
      offer(0, 4'd3, 32'h2A, 32'h0);
      for (int c = 0; c < 4; c++) step(0, 1, 0);
      $display("single result done");

      // collision with rr_ptr forced to 0
      step(0, 1, 1);
      offer(0, 4'd5, 32'h55, 32'h100);
      offer(1, 4'd6, 32'h66, 32'h200);
      for (int c = 0; c < 4; c++) step(0, 1, 0);
      $display("collision done");

      // fairness: both stream 8
      b0 = beats[0]; b1 = beats[1]; n0 = 0; n1 = 0;
      while (n0 < 8 || n1 < 8 || pend_v[0] || pend_v[1]) begin
         if (!pend_v[0] && n0 < 8) begin offer(0, 4'(n0), $urandom, $urandom); n0++; end
         if (!pend_v[1] && n1 < 8) begin offer(1, 4'(n1 + 8), $urandom, $urandom); n1++; end
         step(0, 1, 0);
      end
      for (int c = 0; c < 4; c++) step(0, 1, 0);
      check_count("fair_beats_rs", beats[0] - b0, 8);
      check_count("fair_beats_slb", beats[1] - b1, 8);
      $display("fairness done");

      // streaming: SLB alone idx 0..15
      b1 = beats[1]; n1 = 0;
      while (n1 < 16) begin
         if (!pend_v[1]) begin offer(1, 4'(n1), $urandom, $urandom); n1++; end
         step(0, 1, 0);
      end
      for (int c = 0; c < 4; c++) step(0, 1, 0);
      check_count("stream_beats_slb", beats[1] - b1, 16);
      $display("streaming done");

      // flush with both slots full and a beat on the bus
      offer(0, 4'd1, 32'hA1, 32'h0); offer(1, 4'd2, 32'hA2, 32'h0);
      step(0, 1, 0);
      offer(0, 4'd3, 32'hA3, 32'h0); offer(1, 4'd4, 32'hA4, 32'h0);
      step(0, 1, 0);
      offer(0, 4'd5, 32'hA5, 32'h0);
      step(0, 1, 1);
      for (int c = 0; c < 4; c++) step(0, 1, 0);
      $display("flush done");

      // stall then reset mid-stream
      for (int c = 0; c < 10; c++) begin
         offer(0, 4'($urandom), $urandom, $urandom);
         offer(1, 4'($urandom), $urandom, $urandom);
         if (c >= 3 && c < 6) step(0, 0, 0);
         else if (c == 8) step(1, 1, 0);
         else step(0, 1, 0);
      end
      $display("stall/reset done");

      // random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) < 6) offer(i, 4'($urandom), $urandom, $urandom);
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 3));
      end
      for (int c = 0; c < 4; c++) step(0, 1, 0);
      @(posedge clk);
      #2;
      check_count("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
